// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix and key-report signal bundle
// Ports (master = scanner side):
//   col_in    [3:0] column sense, 1 = key closed in the driven row
//   row_out   [3:0] one-hot active-high row drive
//   key       [4:0] debounced {held, code}, 5'h00 when idle
//   key_pulse [4:0] {1'b1, code} for one cycle on a new valid commit
interface keypad_scan_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [4:0] key;
    logic [4:0] key_pulse;

    modport master (input col_in, output row_out, output key, output key_pulse);
    modport slave  (output col_in, input row_out, input key, input key_pulse);
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame-based debounce
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   kp   keypad_scan_if.master: col_in in; row_out, key, key_pulse out
// Parameters:
//   SCAN_DIV   cycles each row is driven (>= 2)
//   DB_FRAMES  identical full-scan results needed to commit (>= 1)
module keypad_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int DB_FRAMES = 8
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DB_FRAMES + 1);

    // Raw results and key share the {valid, code} encoding, so NONE == 5'h00.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   hits_q, hits_d;
    logic [4:0]    last_q, last_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [4:0]    key_q, key_d;
    logic [4:0]    pulse_q, pulse_d;

    logic          tc;
    logic          frame_end;
    logic [1:0]    row_idx;
    logic [15:0]   hits_now;
    logic [4:0]    raw;
    logic [SW-1:0] stable_nx;

    assign tc        = (cnt_q == CW'(SCAN_DIV - 1));
    assign frame_end = tc && row_q[3];

    always_comb begin
        row_idx = 2'd0;
        case (row_q)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Columns are only trusted at the end of a row's dwell; earlier cycles settle.
    always_comb begin
        hits_now = hits_q;
        if (tc) begin
            hits_now = hits_q | ({12'b0, kp.col_in} << {row_idx, 2'b00});
        end
    end

    // Lowest-numbered closed key wins; scan downwards so the last hit is the lowest.
    always_comb begin
        raw = 5'h00;
        for (int i = 15; i >= 0; i--) begin
            if (hits_now[i]) begin
                raw = {1'b1, 4'(i)};
            end
        end
    end

    always_comb begin
        stable_nx = SW'(1);
        if (raw == last_q) begin
            stable_nx = (stable_q == SW'(DB_FRAMES)) ? stable_q : stable_q + SW'(1);
        end
    end

    always_comb begin
        cnt_d    = tc ? '0 : cnt_q + CW'(1);
        row_d    = tc ? {row_q[2:0], row_q[3]} : row_q;
        hits_d   = frame_end ? 16'h0000 : hits_now;
        last_d   = last_q;
        stable_d = stable_q;
        key_d    = key_q;
        pulse_d  = 5'h00;
        if (frame_end) begin
            last_d   = raw;
            stable_d = stable_nx;
            if (stable_nx == SW'(DB_FRAMES) && raw != key_q) begin
                key_d   = raw;
                // A commit to NONE yields raw == 5'h00, i.e. no pulse.
                pulse_d = raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            row_q    <= 4'b0001;
            hits_q   <= 16'h0000;
            last_q   <= 5'h00;
            stable_q <= '0;
            key_q    <= 5'h00;
            pulse_q  <= 5'h00;
        end else begin
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            hits_q   <= hits_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            key_q    <= key_d;
            pulse_q  <= pulse_d;
        end
    end

    assign kp.row_out   = row_q;
    assign kp.key       = key_q;
    assign kp.key_pulse = pulse_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan (SCAN_DIV=4, DB_FRAMES=3)
module tb_keypad_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] pressed = 16'h0000;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    keypad_scan_if kif ();

    keypad_scan #(.SCAN_DIV(4), .DB_FRAMES(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad matrix: closed keys in the driven row pull their column high.
    always_comb begin
        kif.col_in = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (kif.row_out[r]) kif.col_in = kif.col_in | pressed[r*4 +: 4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Every pulse must match the next scoreboard entry in value and cycle.
    always @(negedge clk) begin
        if (kif.key_pulse !== 5'h00) begin
            if (sb.size() == 0) begin
                chk("pulse_unexpected", {27'b0, kif.key_pulse}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_val", {27'b0, kif.key_pulse}, {27'b0, mon_e.val});
                chk("pulse_cyc", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Idle scan
        repeat (2) @(negedge clk);
        pressed = 16'h0000;
        do_reset();
        chk("rst_key", {27'b0, kif.key}, 32'h0);
        chk("rst_pulse", {27'b0, kif.key_pulse}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            wait_cyc(i);
            chk("row_out", {28'b0, kif.row_out}, 32'h1 << ((i / 4) % 4));
        end
        wait_cyc(64);
        chk("idle_key", {27'b0, kif.key}, 32'h0);

        // Key 1 held from reset release, then released on a frame boundary
        pressed = 16'h0002;
        do_reset();
        sb.push_back('{48, 5'h11});
        wait_cyc(47);
        chk("k1_before", {27'b0, kif.key}, 32'h0);
        wait_cyc(48);
        chk("k1_commit", {27'b0, kif.key}, 32'h11);
        wait_cyc(100);
        chk("k1_hold", {27'b0, kif.key}, 32'h11);
        wait_cyc(112);
        pressed = 16'h0000;
        wait_cyc(159);
        chk("k1_rel_before", {27'b0, kif.key}, 32'h11);
        wait_cyc(160);
        chk("k1_released", {27'b0, kif.key}, 32'h0);
        wait_cyc(200);
        chk("k1_sb_empty", sb.size(), 0);

        // Keys 3 and 6 together, then only 6
        pressed = 16'h0048;
        do_reset();
        sb.push_back('{48, 5'h13});
        wait_cyc(48);
        chk("k36_lowest", {27'b0, kif.key}, 32'h13);
        wait_cyc(64);
        pressed = 16'h0040;
        sb.push_back('{112, 5'h16});
        wait_cyc(111);
        chk("k6_before", {27'b0, kif.key}, 32'h13);
        wait_cyc(112);
        chk("k6_commit", {27'b0, kif.key}, 32'h16);
        wait_cyc(150);
        chk("k6_sb_empty", sb.size(), 0);

        // Key 5 glitch lasting two frames
        pressed = 16'h0000;
        do_reset();
        wait_cyc(16);
        pressed = 16'h0020;
        wait_cyc(48);
        pressed = 16'h0000;
        wait_cyc(130);
        chk("k5_glitch_key", {27'b0, kif.key}, 32'h0);
        chk("k5_sb_empty", sb.size(), 0);

        // Mid-operation reset while key 1 is committed and still held
        pressed = 16'h0002;
        do_reset();
        sb.push_back('{48, 5'h11});
        wait_cyc(60);
        chk("mr_pre_key", {27'b0, kif.key}, 32'h11);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_key", {27'b0, kif.key}, 32'h0);
        chk("mr_pulse", {27'b0, kif.key_pulse}, 32'h0);
        chk("mr_row", {28'b0, kif.row_out}, 32'h1);
        rst = 1'b0;
        sb.push_back('{48, 5'h11});
        wait_cyc(47);
        chk("mr_before", {27'b0, kif.key}, 32'h0);
        wait_cyc(48);
        chk("mr_recommit", {27'b0, kif.key}, 32'h11);
        wait_cyc(80);
        chk("mr_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
